// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero and signed overflow skip the iteration phase.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            start,
  input  logic [2:0]      control,
  input  logic [XLEN-1:0] i1,
  input  logic [XLEN-1:0] i2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [2:0]        op;
  logic [XLEN-1:0]   hi, lo, opb;
  logic [5:0]        cnt;
  logic              neg_q, neg_r;

  logic              a_signed, b_signed, a_neg, b_neg, b_zero, is_div;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [XLEN:0]     sum, shifted, diff;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result;

  // Operands are reduced to magnitudes up front; the signs are reapplied once at the end.
  always_comb begin
    is_div   = control[2];
    a_signed = (control == 3'b001) || (control == 3'b010) ||
               (control == 3'b100) || (control == 3'b110);
    b_signed = (control == 3'b001) || (control == 3'b100) || (control == 3'b110);
    a_neg    = a_signed && i1[XLEN-1];
    b_neg    = b_signed && i2[XLEN-1];
    a_mag    = a_neg ? -i1 : i1;
    b_mag    = b_neg ? -i2 : i2;
    b_zero   = (i2 == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic div_zero_in, ovf_in;

  always_comb begin
    div_zero_in = is_div && b_zero;
    ovf_in      = is_div && !control[0] &&
                  (i1 == {1'b1, {(XLEN-1){1'b0}}}) && (i2 == {XLEN{1'b1}});
  end
`endif

  // Multiply keeps {hi,lo} as the product with the multiplier draining out of lo;
  // divide keeps hi as partial remainder while lo shifts dividend out and quotient in.
  always_comb begin
    nxt_hi  = hi;
    nxt_lo  = lo;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (op[2]) begin
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, opb};
      if (shifted >= {1'b0, opb}) begin
        nxt_hi = diff[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -lo : lo;
    rem_fix  = neg_r ? -hi : hi;
    case (op)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quot_fix;
      default:                result = rem_fix;
    endcase
  end

  // A zero divisor never flips the quotient, so it stays all ones; the remainder
  // falls out as the original dividend once its sign is restored.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      o     <= '0;
      cnt   <= '0;
      op    <= '0;
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            op    <= control;
            cnt   <= '0;
            neg_q <= (a_neg ^ b_neg) && !b_zero;
            neg_r <= a_neg;
            hi    <= '0;
            lo    <= is_div ? a_mag : b_mag;
            opb   <= is_div ? b_mag : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
            if (div_zero_in || ovf_in) begin
              hi    <= div_zero_in ? a_mag : '0;
              lo    <= div_zero_in ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
              state <= DONE;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end
        end
        RUN: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          o     <= result;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a driver pushes reference results, a monitor checks each done strobe.
// Build with MULDIV_EARLY_OUT_EN defined to expect single-edge latency on divide special cases.
module tb_muldiv_unit;

  logic        CLK;
  logic        RESET_N;
  logic        start;
  logic [2:0]  control;
  logic [31:0] i1, i2;
  logic        busy, done;
  logic [31:0] o;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          lat;
    string       name;
  } sb_t;

  sb_t         sbq[$];
  int          cyc;
  int          checks;
  int          passes;
  logic [31:0] last_o;

  muldiv_unit #(.XLEN(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (start),
    .control (control),
    .i1      (i1),
    .i2      (i2),
    .busy    (busy),
    .done    (done),
    .o       (o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, wanted %h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Reference results straight from the RV32M definitions using wide arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        sa, sb, ua, ub, p;
    logic signed [31:0] as32, bs32;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    as32 = a;
    bs32 = b;
    case (c)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (b == 32'h0) return c[1] ? a : 32'hffffffff;
        if (!c[0] && a == 32'h80000000 && b == 32'hffffffff) return c[1] ? 32'h0 : 32'h80000000;
        case (c)
          3'b100:  return as32 / bs32;
          3'b101:  return a / b;
          3'b110:  return as32 % bs32;
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (c[2] && (b == 32'h0 || (!c[0] && a == 32'h80000000 && b == 32'hffffffff))) return 1;
`endif
    return 33;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RESET_N && done) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 32'h1, 32'h0);
      end else begin
        sb_t item;
        item = sbq.pop_front();
        checkOutput({item.name, "_result"}, o, item.exp);
        checkOutput({item.name, "_latency"}, 32'(cyc - item.acc), 32'(item.lat));
        checkOutput({item.name, "_busy_at_done"}, {31'h0, busy}, 32'h0);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [2:0] c, input logic [31:0] a,
                               input logic [31:0] b, input int restart_at, input int reset_at);
    sb_t item;
    bit  seen;
    int  lat;
    @(negedge CLK);
    start   = 1'b1;
    control = c;
    i1      = a;
    i2      = b;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    control = 3'($urandom);
    i1      = $urandom;
    i2      = $urandom;
    lat       = refLatency(c, a, b);
    item.exp  = refModel(c, a, b);
    item.acc  = cyc;
    item.lat  = lat;
    item.name = name;
    sbq.push_back(item);
    checkOutput({name, "_busy"}, {31'h0, busy}, (lat == 33) ? 32'h1 : 32'h0);
    checkOutput({name, "_o_hold"}, o, last_o);
    if (reset_at > 0) begin
      repeat (reset_at - 1) @(posedge CLK);
      #2;
      RESET_N = 1'b0;
      #1;
      checkOutput({name, "_rst_busy"}, {31'h0, busy}, 32'h0);
      checkOutput({name, "_rst_done"}, {31'h0, done}, 32'h0);
      checkOutput({name, "_rst_o"}, o, 32'h0);
      sbq.delete();
      last_o = 32'h0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      return;
    end
    if (restart_at > 0) begin
      repeat (restart_at - 1) @(negedge CLK);
      start   = 1'b1;
      control = 3'b000;
      i1      = 32'h1234;
      i2      = 32'h10;
      @(posedge CLK);
      #1;
      start = 1'b0;
      checkOutput({name, "_busy_after_restart"}, {31'h0, busy}, 32'h1);
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput({name, "_timeout"}, 32'h0, 32'h1);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end
    last_o = item.exp;
  endtask

  initial begin
    logic [2:0]  c;
    logic [31:0] a, b;
    int          sel;
    cyc     = 0;
    checks  = 0;
    passes  = 0;
    last_o  = 32'h0;
    RESET_N = 1'b0;
    start   = 1'b0;
    control = 3'b000;
    i1      = 32'h0;
    i2      = 32'h0;
    #3;
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_o", o, 32'h0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    applyStimulus("mul_neg",   3'b000, 32'd7,        32'hfffffffd, 0, 0);
    applyStimulus("mulhu_max", 3'b011, 32'hffffffff, 32'hffffffff, 0, 0);
    applyStimulus("mulh_m1",   3'b001, 32'hffffffff, 32'hffffffff, 0, 0);
    applyStimulus("mulhsu",    3'b010, 32'hffffffff, 32'd2,        0, 0);
    applyStimulus("div_neg",   3'b100, 32'hfffffff9, 32'd2,        0, 0);
    applyStimulus("rem_neg",   3'b110, 32'hfffffff9, 32'd2,        0, 0);
    applyStimulus("divu",      3'b101, 32'd100,      32'd7,        0, 0);
    applyStimulus("divu_z",    3'b101, 32'd5,        32'd0,        0, 0);
    applyStimulus("remu_z",    3'b111, 32'd5,        32'd0,        0, 0);
    applyStimulus("div_z_neg", 3'b100, 32'hfffffff0, 32'd0,        0, 0);
    applyStimulus("rem_z_neg", 3'b110, 32'hfffffff0, 32'd0,        0, 0);
    applyStimulus("div_ovf",   3'b100, 32'h80000000, 32'hffffffff, 0, 0);
    applyStimulus("rem_ovf",   3'b110, 32'h80000000, 32'hffffffff, 0, 0);
    applyStimulus("restart",   3'b000, 32'd1000,     32'd3000,     10, 0);
    repeat (40) @(negedge CLK);
    applyStimulus("reset_mid", 3'b101, 32'hdeadbeef, 32'd77,       0, 15);
    applyStimulus("mul_3x4",   3'b000, 32'd3,        32'd4,        0, 0);

    for (int k = 0; k < 30; k++) begin
      c   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'h0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hffffffff; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      if (sel == 3) a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(0, 1000))};
      applyStimulus("random", c, a, b, 0, 0);
    end

    repeat (40) @(negedge CLK);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by %0t, wanted completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
